tlb_op_sequencer: RTL

Sequences all TLB maintenance operations (read, write, invalidate, clear) onto the TLB's single control port (read_addr/we/write_data/invalidate/clear). It arbitrates between two requesters: the pipeline's privileged-instruction path (tlbr/tlbw/tlbi/tlbc) and a maintenance port used by the debug/MMIO path. It also issues an automatic clear after reset, captures the registered read result, and returns it over a valid/ready response channel. The block sits between the pipeline's execute/memory stage and the TLB and shares the TLB's clk_en.

---
 rtl/tlb_pkg.sv | 14 +
 rtl/tlb_op_arbiter.sv | 25 ++
 rtl/tlb_op_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: op encodings, field positions and FSM states shared by the TLB op sequencer.
package tlb_pkg;
  typedef enum logic [1:0] {
    TLB_OP_READ  = 2'd0,
    TLB_OP_WRITE = 2'd1,
    TLB_OP_INVAL = 2'd2,
    TLB_OP_CLEAR = 2'd3
  } tlb_op_e;
  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;
  localparam int VPN_MSB = 31;
  localparam int VPN_LSB = 12;
  localparam int PPN_MSB = 26;
  localparam int TLB_W = 27;
endpackage

// File: rtl/tlb_op_arbiter.sv
// tlb_op_arbiter: pipeline-first two-way arbiter that forces maintenance after STARVE_LIMIT pipeline wins.
module tlb_op_arbiter
  import tlb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic en,
  input  logic p_valid,
  input  logic m_valid,
  output logic grant,
  output logic sel
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  always_comb begin
    sel = m_valid && (!p_valid || cnt == CW'(STARVE_LIMIT));
    grant = en && (p_valid || m_valid);
  end
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (clk_en) cnt <= (!m_valid || (grant && sel)) ? '0 : grant ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: serialises pipeline and maintenance TLB ops onto the single TLB control port.
module tlb_op_sequencer
  import tlb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit BOOT_CLEAR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [1:0]       p_op,
  input  logic [31:0]      p_addr,
  input  logic [31:0]      p_data,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [1:0]       m_op,
  input  logic [31:0]      m_addr,
  input  logic [31:0]      m_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [TLB_W-1:0] rsp_data,
  output logic [31:0]      tlb_read_addr,
  output logic [31:0]      tlb_write_data,
  output logic             tlb_we,
  output logic             tlb_invalidate,
  output logic             tlb_clear,
  input  logic [TLB_W-1:0] tlb_read_result,
  output logic             busy
);
  state_e state, next;
  tlb_op_e op;
  logic src, grant, sel, live, issue;
  logic [31:0] addr, data;
  logic [TLB_W-1:0] rdata;
  tlb_op_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .en(state == S_IDLE && clk_en && !rst),
    .p_valid(p_valid),
    .m_valid(m_valid),
    .grant(grant),
    .sel(sel)
  );
  always_ff @(posedge clk)
    if (rst) state <= BOOT_CLEAR ? S_BOOT : S_IDLE;
    else if (clk_en) state <= next;
  always_comb begin
    next = state == S_BOOT    ? S_IDLE :
           state == S_IDLE    ? (grant ? S_ISSUE : S_IDLE) :
           state == S_ISSUE   ? (op == TLB_OP_READ ? S_CAPTURE : S_RESP) :
           state == S_CAPTURE ? S_RESP :
           state == S_RESP    ? (rsp_ready ? S_IDLE : S_RESP) : S_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      op <= TLB_OP_READ;
      src <= 1'b0;
      addr <= '0;
      data <= '0;
      rdata <= '0;
    end else if (clk_en) begin
      if (grant) begin
        op <= tlb_op_e'(sel ? m_op : p_op);
        src <= sel;
        addr <= sel ? m_addr : p_addr;
        data <= sel ? m_data : p_data;
        rdata <= '0;
      end
      if (state == S_CAPTURE) rdata <= tlb_read_result;
    end
  // Outputs are forced low while rst is high so nothing leaks toward the TLB during reset.
  always_comb begin
    live = !rst;
    issue = live && state == S_ISSUE;
    p_ready = grant && !sel;
    m_ready = grant && sel;
    busy = live && state != S_IDLE;
    rsp_valid = live && state == S_RESP;
    rsp_src = rsp_valid && src;
    rsp_data = rsp_valid ? rdata : '0;
    tlb_we = issue && op == TLB_OP_WRITE;
    tlb_invalidate = issue && op == TLB_OP_INVAL;
    tlb_clear = (live && state == S_BOOT) || (issue && op == TLB_OP_CLEAR);
    tlb_read_addr = (issue || (live && state == S_CAPTURE)) ? addr : '0;
    tlb_write_data = (issue && op != TLB_OP_READ) ? data : '0;
  end
endmodule
